// File: rtl/fourbit_4to1mux_pkg.sv
// Shared constants for the 4-bit 4:1 word multiplexer.
package fourbit_4to1mux_pkg;

    // Default data width of each input word and of both outputs.
    localparam int DEF_WIDTH = 4;

    // Select encodings: which input word appears on y.
    localparam logic [1:0] SEL_I0 = 2'b00;
    localparam logic [1:0] SEL_I1 = 2'b01;
    localparam logic [1:0] SEL_I2 = 2'b10;
    localparam logic [1:0] SEL_I3 = 2'b11;

endpackage : fourbit_4to1mux_pkg

// File: rtl/fourbit_4to1mux_if.sv
// Bus bundle for the 4:1 word multiplexer: select, data words, load enable
// and both outputs. The master drives select/data, the slave is the mux.
interface fourbit_4to1mux_if
    import fourbit_4to1mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [1:0]       sel;
    logic [WIDTH-1:0] i3;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i0;
    logic             en;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;

    modport master (
        output sel, i3, i2, i1, i0, en,
        input  y, y_q
    );

    modport slave (
        input  sel, i3, i2, i1, i0, en,
        output y, y_q
    );

endinterface : fourbit_4to1mux_if

// File: rtl/fourbit_4to1mux_mux2.sv
// WIDTH-wide 2:1 multiplexer; leaf of the 4:1 select tree.
module fourbit_4to1mux_mux2
    import fourbit_4to1mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             s_i,
    output logic [WIDTH-1:0] y_o
);

    // Pick a_i when s_i=0, b_i when s_i=1; an unknown select yields all-X.
    always_comb begin
        case (s_i)
            1'b0:    y_o = a_i;
            1'b1:    y_o = b_i;
            default: y_o = 'x;
        endcase
    end

endmodule : fourbit_4to1mux_mux2

// File: rtl/fourbit_4to1mux.sv
// 4-bit-wide 4:1 word multiplexer with a combinational output y and an
// optional registered copy y_q (async active-low reset, load enable).
// y never depends on clk, rst_n or en, so purely combinational users may
// tie those off.
module fourbit_4to1mux
    import fourbit_4to1mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    fourbit_4to1mux_if.slave  bus
);

    logic [WIDTH-1:0] lo_pair;
    logic [WIDTH-1:0] hi_pair;
    logic [WIDTH-1:0] y_sel;
    logic [WIDTH-1:0] yq_d;
    logic [WIDTH-1:0] yq_q;

    // sel[0] chooses within each input pair, sel[1] between the pair results.
    fourbit_4to1mux_mux2 #(.WIDTH(WIDTH)) u_mux_lo (
        .a_i (bus.i0),
        .b_i (bus.i1),
        .s_i (bus.sel[0]),
        .y_o (lo_pair)
    );

    fourbit_4to1mux_mux2 #(.WIDTH(WIDTH)) u_mux_hi (
        .a_i (bus.i2),
        .b_i (bus.i3),
        .s_i (bus.sel[0]),
        .y_o (hi_pair)
    );

    fourbit_4to1mux_mux2 #(.WIDTH(WIDTH)) u_mux_out (
        .a_i (lo_pair),
        .b_i (hi_pair),
        .s_i (bus.sel[1]),
        .y_o (y_sel)
    );

    // Next value of the output register: load the selected word when enabled.
    always_comb begin
        yq_d = yq_q;
        if (bus.en) begin
            yq_d = y_sel;
        end
    end

    // Output register; reset clears it immediately, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yq_q <= '0;
        end else begin
            yq_q <= yq_d;
        end
    end

    assign bus.y   = y_sel;
    assign bus.y_q = yq_q;

endmodule : fourbit_4to1mux

// File: tb/tb_fourbit_4to1mux.sv
// Self-checking bench for fourbit_4to1mux: directed cases followed by
// randomized traffic compared against an array-indexed reference model.
module tb_fourbit_4to1mux;
    import fourbit_4to1mux_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst_n;

    fourbit_4to1mux_if #(.WIDTH(W)) bus ();

    fourbit_4to1mux #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference state: the four data words indexed by select, and the
    // expected content of the output register.
    logic [W-1:0] words [4];
    logic [1:0]   sel_m;
    logic [W-1:0] q_exp;

    function automatic logic [W-1:0] ref_y();
        return words[sel_m];
    endfunction

    task automatic drive(input logic [1:0] s, input logic [W-1:0] w3,
                         input logic [W-1:0] w2, input logic [W-1:0] w1,
                         input logic [W-1:0] w0);
        sel_m    = s;
        words[3] = w3;
        words[2] = w2;
        words[1] = w1;
        words[0] = w0;
        bus.sel  = s;
        bus.i3   = w3;
        bus.i2   = w2;
        bus.i1   = w1;
        bus.i0   = w0;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic probe;
        logic [W-1:0] held;
        n_vec = 0;
        n_err = 0;
        q_exp = '0;

        // Power-up under reset.
        rst_n  = 1'b0;
        bus.en = 1'b0;
        drive(SEL_I0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        #2;
        chk("reset_yq", bus.y_q, 4'b0000);

        // Static select sweep; y follows sel in the same time step.
        drive(SEL_I0, 4'b0111, 4'b1011, 4'b1101, 4'b1110);
        #1 chk("sweep_sel00", bus.y, 4'b1110);
        drive(SEL_I1, 4'b0111, 4'b1011, 4'b1101, 4'b1110);
        #1 chk("sweep_sel01", bus.y, 4'b1101);
        drive(SEL_I2, 4'b0111, 4'b1011, 4'b1101, 4'b1110);
        #1 chk("sweep_sel10", bus.y, 4'b1011);
        drive(SEL_I3, 4'b0111, 4'b1011, 4'b1101, 4'b1110);
        #1 chk("sweep_sel11", bus.y, 4'b0111);

        // Bit-set usage: one-hot candidates.
        drive(SEL_I1, 4'b1000, 4'b0100, 4'b0010, 4'b0001);
        #1 chk("bitset_sel01", bus.y, 4'b0010);
        drive(SEL_I2, 4'b1000, 4'b0100, 4'b0010, 4'b0001);
        #1 chk("bitset_sel10", bus.y, 4'b0100);
        drive(SEL_I3, 4'b1000, 4'b0100, 4'b0010, 4'b0001);
        #1 chk("bitset_sel11", bus.y, 4'b1000);

        // Clear bit 0 of 1111; toggling non-selected words must not matter.
        drive(SEL_I0, 4'b0111, 4'b1011, 4'b1101, 4'b1110);
        #1 chk("bitclr_sel00", bus.y, 4'b1110);
        for (int k = 0; k < 4; k++) begin
            drive(SEL_I0, W'($urandom), W'($urandom), W'($urandom), 4'b1110);
            #1 chk("nonsel_toggle", bus.y, 4'b1110);
        end
        chk("yq_held_in_reset", bus.y_q, 4'b0000);

        // Release reset mid-cycle; y_q stays zero until a loading edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("yq_after_release", bus.y_q, 4'b0000);
        bus.en = 1'b1;
        drive(SEL_I3, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        @(posedge clk);
        #1 chk("yq_load", bus.y_q, 4'b1010);

        // Hold with en=0 while the selected word changes.
        @(negedge clk);
        bus.en = 1'b0;
        drive(SEL_I3, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        repeat (2) @(posedge clk);
        #1 chk("yq_hold", bus.y_q, 4'b1010);
        chk("y_during_hold", bus.y, 4'b0101);

        // Asynchronous reset between edges.
        @(negedge clk);
        drive(SEL_I3, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        #2 rst_n = 1'b0;
        #1 chk("yq_async_clear", bus.y_q, 4'b0000);
        chk("y_ignores_reset", bus.y, 4'b1010);
        @(negedge clk);
        rst_n = 1'b1;

        // Unknown select; the all-X check only applies on a 4-state simulator.
        probe = 1'bx;
        drive(SEL_I1, 4'b0011, 4'b0101, 4'b1001, 4'b0110);
        bus.sel = 2'bx1;
        #1;
        if (probe === 1'bx) begin
            chk("x_select", bus.y, 4'bxxxx);
        end
        bus.sel = SEL_I1;
        #1 chk("x_select_recover", bus.y, 4'b1001);

        // Randomized traffic with occasional enable drops and resets.
        q_exp = '0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            drive(2'($urandom), W'($urandom), W'($urandom), W'($urandom),
                  W'($urandom));
            bus.en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                rst_n = 1'b0;
                q_exp = '0;
                #1 chk("rand_async_reset", bus.y_q, q_exp);
                rst_n = 1'b1;
            end
            #1 chk("rand_y", bus.y, ref_y());
            held = bus.en ? ref_y() : q_exp;
            @(posedge clk);
            q_exp = held;
            #1 chk("rand_yq", bus.y_q, q_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fourbit_4to1mux

// File: doc/fourbit_4to1mux.md
Name: fourbit_4to1mux

Overview:
- Four-input, 4-bit-wide word multiplexer. A 2-bit select picks one of four input words.
- Primary output y is purely combinational and is used directly by fourbit_bitset to build the bit-set result. For that use, index drives sel and the four candidate words drive i3..i0.
- An optional registered copy (y_q) is provided for pipelined users. It is clocked by the single block clock and has an asynchronous active-low reset.

Parameters:
- WIDTH, 4, bit width of each data input and of both outputs. Fixed at 4 for the fourbit_bitset instance.

Ports:
- clk  input  1  block clock; rising edge used; only y_q depends on it.
- rst_n  input  1  asynchronous active-low reset; clears y_q only.
- sel  input  2  select: 2'b00 picks i0, 01 picks i1, 10 picks i2, 11 picks i3.
- i3  input  WIDTH  data word chosen when sel=11.
- i2  input  WIDTH  data word chosen when sel=10.
- i1  input  WIDTH  data word chosen when sel=01.
- i0  input  WIDTH  data word chosen when sel=00.
- en  input  1  load enable for y_q; tie high for free-running capture.
- y  output  WIDTH  combinational selected word.
- y_q  output  WIDTH  registered selected word.

Behaviour:
- y = i[sel], fully combinational with zero latency. It reacts to any change on sel or on the selected input within the same delta/time step.
- y has no dependence on clk, rst_n or en. Reset does not affect y.
- sel containing X or Z: y is driven to all-X. The decode must be complete, with no latch and a default branch assigning X.
- Non-selected inputs have no effect on y.
- y_q, asynchronous reset: while rst_n=0, y_q = 0 immediately, regardless of clk.
- y_q, normal operation: on a rising clk edge with rst_n=1 and en=1, y_q <= y, giving one cycle of latency.
- y_q hold: with en=0, y_q holds its value.
- Reset deasserted mid-cycle: y_q stays 0 until the first qualifying rising edge.
- Reset asserted mid-operation: y_q clears without waiting for an edge.
- Combinational-only users (such as fourbit_bitset) may leave clk, rst_n and en unconnected or tied off. y must remain correct in that case.
- No width growth or arithmetic. The output width equals the input width, and bit i of y comes from bit i of the selected input.

Decomposition:
- Shared package: constants SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11, and the default WIDTH=4.
- Optional sub-module mux2 (WIDTH-wide 2:1). Three instances form the 4:1 tree: sel[0] chooses within the (i0,i1) and (i2,i3) pairs, and sel[1] chooses between the pair results.
- The output register lives in the top module.

Test Plan:
- Static select sweep: i3=4'b0111, i2=4'b1011, i1=4'b1101, i0=4'b1110, with sel stepping 00,01,10,11. Required y: 1110, 1101, 1011, 0111 in the same time step.
- Bit-set usage, set one bit of 0000 to value=1: i3=1000, i2=0100, i1=0010, i0=0001.
  - sel=01 -> y=0010.
  - sel=10 -> y=0100.
  - sel=11 -> y=1000.
- Bit-set usage, clear bit 0 of 1111 to value=0: i3=0111, i2=1011, i1=1101, i0=1110, sel=00 -> y=1110. A non-selected input toggling must leave y unchanged.
- Register path: rst_n=0 -> y_q=0000. Release reset, en=1, sel=11, i3=1010; after one rising edge y_q=1010. Then set en=0 and change i3 to 0101; y_q stays 1010 across edges.
- Asynchronous reset mid-operation: with y_q=1010, drive rst_n low between clock edges -> y_q=0000 immediately while y still shows 1010.
- X select: sel=2'bx1 -> y all X. Then sel=01 -> y equals i1 again.
